// File: rtl/milano_pkg.sv
`default_nettype none
// ============================================================================
// Module      : milano_pkg
// Description : Shared core types and constants for the Milano front end.
// Revision    : 1.0 - initial release
// ============================================================================
package milano_pkg;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_if
// Description : Fetch-side handshake between instruction RAM, buffer and decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if;

    logic        req_valid_i;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_i;
    logic        flush_i;
    logic        id_ready_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        full_o;

    modport master (
        output req_valid_i, instr_addr_i, instr_rdata_i, flush_i, id_ready_i,
        input  valid_o, instr_o, pc_o, full_o
    );

    modport slave (
        input  req_valid_i, instr_addr_i, instr_rdata_i, flush_i, id_ready_i,
        output valid_o, instr_o, pc_o, full_o
    );

endinterface
`default_nettype wire

// File: rtl/fetch_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf_fifo
// Description : Circular store of fetch entries with pointer/count tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf_fifo
    import milano_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic                       clk_i,
    input  wire logic                       rst_i,
    input  wire logic                       i_flush,
    input  wire logic                       i_push,
    input  wire fetch_entry_t               i_wdata,
    input  wire logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0]      o_count,
    output fetch_entry_t                    o_rdata
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // Explicit wrap so non-power-of-two depths never address past the array.
    function automatic logic [c_PW-1:0] f_next_ptr(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_push = i_push & ~i_flush & ~w_full;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= f_next_ptr(r_wptr);
            if (w_pop)  r_rptr <= f_next_ptr(r_rptr);
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(i_push && !i_flush && w_full));

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Credit-based instruction fetch buffer in front of decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import milano_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    fetch_buffer_if.slave  bus
);

    localparam int c_CW = $clog2(DEPTH + 1);

    logic            r_rsp_valid;
    logic [31:0]     r_rsp_addr;
    logic [c_CW-1:0] w_count;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_head;

    // Track the single outstanding RAM read; its data lands one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_rsp_valid <= 1'b0;
        else       r_rsp_valid <= bus.req_valid_i & ~bus.flush_i;
        r_rsp_addr <= bus.instr_addr_i;
    end

    assign w_wdata = '{pc: r_rsp_addr, instr: bus.instr_rdata_i};
    assign w_push  = r_rsp_valid & ~bus.flush_i;
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & bus.id_ready_i & ~bus.flush_i;

    fetch_buf_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_flush (bus.flush_i),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_rdata (w_head)
    );

    // In-flight read counts against the credit so its data always has a slot.
    assign bus.full_o  = ({1'b0, w_count} + {{c_CW{1'b0}}, r_rsp_valid}) >= (c_CW + 1)'(DEPTH);
    assign bus.valid_o = w_valid;
    assign bus.instr_o = w_valid ? w_head.instr : c_NOP_INSTR;
    assign bus.pc_o    = w_valid ? w_head.pc    : 32'h0;

    a_no_issue_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.req_valid_i && bus.full_o));

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Scoreboard bench for fetch_buffer with a one-cycle RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
    import milano_pkg::*;

    localparam int c_DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    fetch_entry_t sbq[$];

    fetch_buffer_if bus();

    fetch_buffer #(
        .DEPTH (c_DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h80) return 32'h0050_0093;
        return 32'hA500_0000 | {8'h00, a[23:0]};
    endfunction

    // Instruction RAM: data for the address issued in a cycle returns the next cycle.
    always @(posedge clk) bus.instr_rdata_i <= ram_word(bus.instr_addr_i);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst && !bus.flush_i) begin
            if (bus.valid_o) begin
                if (bus.id_ready_i) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got pc %h with no entry expected", bus.pc_o);
                    end else begin
                        e = sbq.pop_front();
                        check("sb_pc", bus.pc_o, e.pc);
                        check("sb_instr", bus.instr_o, e.instr);
                    end
                end
            end else begin
                check("idle_instr", bus.instr_o, c_NOP_INSTR);
                check("idle_pc", bus.pc_o, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        fetch_entry_t e;
        bus.req_valid_i  = v;
        bus.instr_addr_i = a;
        if (v && !bus.flush_i && !rst) begin
            e = {a, ram_word(a)};
            sbq.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d entries left, expected 0", name, sbq.size());
        end
        tick();
        check({name, "_valid_after"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        bus.req_valid_i  = 1'b0;
        bus.instr_addr_i = 32'h0;
        bus.flush_i      = 1'b0;
        bus.id_ready_i   = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_full",  32'(bus.full_o),  32'd0);
        check("rst_instr", bus.instr_o, c_NOP_INSTR);
        check("rst_pc",    bus.pc_o,    32'h0);

        // Two-cycle latency from an empty buffer
        bus.id_ready_i = 1'b1;
        drive(1'b1, 32'h80);
        tick();
        drive(1'b0, 32'h0);
        check("lat_n1_valid", 32'(bus.valid_o), 32'd0);
        tick();
        check("lat_n2_valid", 32'(bus.valid_o), 32'd1);
        check("lat_n2_pc",    bus.pc_o,    32'h80);
        check("lat_n2_instr", bus.instr_o, 32'h0050_0093);
        tick();
        check("lat_n3_valid", 32'(bus.valid_o), 32'd0);

        // Credit exhaustion with decode stalled
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'h100);
        tick();
        check("cred_full_b", 32'(bus.full_o), 32'd0);
        drive(1'b1, 32'h104);
        tick();
        check("cred_full_c", 32'(bus.full_o), 32'd0);
        drive(1'b1, 32'h108);
        tick();
        check("cred_full_d", 32'(bus.full_o), 32'd1);
        drive(1'b0, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cred_full_hold", 32'(bus.full_o), 32'd1);
        end
        check("cred_stored", 32'(sbq.size()), 32'd3);
        bus.id_ready_i = 1'b1;
        wait_drain("cred_drain");

        // Flush in the cycle the 0x200 response returns
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'h1F8);
        tick();
        drive(1'b1, 32'h1FC);
        tick();
        drive(1'b1, 32'h200);
        tick();
        drive(1'b0, 32'h0);
        bus.flush_i = 1'b1;
        sbq.delete();
        tick();
        bus.flush_i = 1'b0;
        check("flush_valid", 32'(bus.valid_o), 32'd0);
        check("flush_full",  32'(bus.full_o),  32'd0);
        bus.id_ready_i = 1'b1;
        drive(1'b1, 32'h400);
        tick();
        drive(1'b0, 32'h0);
        tick();
        check("post_flush_valid", 32'(bus.valid_o), 32'd1);
        check("post_flush_pc",    bus.pc_o, 32'h400);
        wait_drain("post_flush");

        // A request issued together with a flush is dropped
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h300);
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_req_drop", 32'(bus.valid_o), 32'd0);
        end

        // Streaming one instruction per cycle
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) drive(1'b1, 32'(i * 4));
            else        drive(1'b0, 32'h0);
            tick();
            check("stream_full", 32'(bus.full_o), 32'd0);
            if (i >= 1) begin
                check("stream_valid", 32'(bus.valid_o), 32'd1);
                check("stream_pc",    bus.pc_o, 32'((i - 1) * 4));
            end
        end
        tick();
        check("stream_end_valid", 32'(bus.valid_o), 32'd0);

        // Reset while full
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'h500);
        tick();
        drive(1'b1, 32'h504);
        tick();
        drive(1'b1, 32'h508);
        tick();
        drive(1'b0, 32'h0);
        tick();
        check("prerst_full",  32'(bus.full_o),  32'd1);
        check("prerst_valid", 32'(bus.valid_o), 32'd1);
        rst = 1'b1;
        sbq.delete();
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_instr", bus.instr_o, c_NOP_INSTR);
        check("midrst_pc",    bus.pc_o,    32'h0);
        check("midrst_full",  32'(bus.full_o), 32'd0);

        // Random decode back-pressure with credit-respecting issue
        addr = 32'h1000;
        for (int i = 0; i < 1000; i++) begin
            bus.id_ready_i = 1'($urandom_range(0, 1));
            if (!bus.full_o && $urandom_range(0, 3) != 0) begin
                drive(1'b1, addr);
                addr = addr + 32'd4;
            end else begin
                drive(1'b0, 32'h0);
            end
            tick();
        end
        drive(1'b0, 32'h0);
        bus.id_ready_i = 1'b1;
        wait_drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
